mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
//
// PURPOSE
// - Shares the single external memory bus between the CPU control unit and one
//   DMA/peripheral requester, and inserts a fixed number of wait states per access.
// - Sits between the control unit and the memory; feeds back the CPU's n_mem_rdy.
// - Drives the address/data mux select and the bus-enable strobe.
// - One access per grant; re-arbitrates back-to-back with no idle cycle.
//
// PARAMETERS
// WAIT_STATES    1  extra cycles per access (0..15); access = WAIT_STATES+1 cycles
// MAX_DMA_BURST  4  max consecutive DMA grants while cpu_req pending (priority build only, 1..7)
//
// PORTS
// clk        in   1  clock, all state on posedge
// n_rst      in   1  asynchronous reset, active low
// cpu_req    in   1  CPU requests a memory access; held until cpu_n_rdy low
// cpu_n_rdy  out  1  active low; low for exactly the final cycle of a CPU access
// dma_req    in   1  DMA requests an access; held until dma_ack
// dma_ack    out  1  high for exactly the final cycle of a DMA access
// bus_sel    out  1  0 = CPU owns address/data mux, 1 = DMA
// n_bus_en   out  1  active low; low throughout every granted access
//
// BEHAVIOUR
// - Reset (async, any time, including mid-access):
//   - state=IDLE, n_bus_en=1, cpu_n_rdy=1, dma_ack=0, bus_sel=0.
//   - cnt=0, burst=0, last_owner=DMA, so the CPU wins the first tie.
// - States: IDLE, CPU_ACC, DMA_ACC. All outputs are decoded from registers only (Moore).
// - Arbitration runs on a posedge in IDLE, or on the final cycle of an access (cnt==0).
//   - Only one requester: grant it.
//   - Both requesting: grant the one != last_owner (round-robin).
//   - Neither requesting: go to (or stay in) IDLE.
// - On grant: enter xxx_ACC, load cnt=WAIT_STATES, set bus_sel, set last_owner.
//   - bus_sel changes only at a grant; it holds its value in IDLE.
// - In xxx_ACC with cnt!=0: cnt decrements each clk.
// - In xxx_ACC with cnt==0: this is the final cycle.
//   - Assert cpu_n_rdy=0 or dma_ack=1.
//   - Arbitrate for the next cycle.
// - Latency: req sampled high in IDLE at edge N -> n_bus_en low from cycle N+1.
//   - Completion strobe in cycle N+1+WAIT_STATES.
// - WAIT_STATES=0: a requester held high gets one access per cycle.
//   - Under contention, accesses alternate per cycle.
// - Request dropped mid-access (protocol violation):
//   - The access still completes and the ack/rdy still pulses; no abort.
//   - No new grant to that requester unless its req is high at arbitration.
// - Request present on the same edge an access ends: it competes in that same
//   arbitration, so there are zero dead cycles.
// - n_bus_en=1 only in IDLE.
// - burst counter: increments on each DMA grant while cpu_req=1.
//   - Clears on any CPU grant or when cpu_req=0; saturates at MAX_DMA_BURST.
//   - Maintained in both builds; used only in the priority build.
//
// CONFIGURATION
// - ARB_DMA_PRIORITY_EN defined: ties go to DMA, except when burst==MAX_DMA_BURST;
//   then the CPU is granted and burst clears.
// - ARB_DMA_PRIORITY_EN undefined: pure round-robin as above; MAX_DMA_BURST ignored.
//
// TESTING
// - Reset mid DMA access (WAIT_STATES=3, cnt=2): n_rst low -> same cycle n_bus_en=1,
//   dma_ack=0, cpu_n_rdy=1, bus_sel=0. After release, CPU wins the first tie.
// - CPU alone, WAIT_STATES=1: cpu_req high at edge 0 -> n_bus_en low cycles 1-2,
//   bus_sel=0, cpu_n_rdy low only in cycle 2. With cpu_req dropped at cycle 2,
//   state=IDLE in cycle 3.
// - Round-robin, WAIT_STATES=0, both reqs held high: grant order CPU,DMA,CPU,DMA;
//   n_bus_en continuously low; cpu_n_rdy and dma_ack alternate each cycle.
// - ARB_DMA_PRIORITY_EN, MAX_DMA_BURST=4, WAIT_STATES=0, both held high:
//   sequence DMA x4, CPU x1, DMA x4, CPU x1.
// - DMA drops dma_req during cycle 1 of a 3-cycle access (WAIT_STATES=2):
//   dma_ack still pulses in cycle 3; next state IDLE when cpu_req=0.
// - cpu_req rises on the final cycle of a DMA access: CPU is granted on the next
//   cycle with no IDLE; bus_sel switches 1->0 exactly there.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the external memory bus between the CPU control unit and one
//   DMA/peripheral requester. Each grant covers exactly one access lasting
//   WAIT_STATES+1 cycles. The final cycle of an access is also an arbitration
//   point, so back-to-back accesses run with no idle cycle between them.
//
//   Outputs are Moore: they are decoded from state, cnt and bus_sel only.
//
//   Optional feature macro: ARB_DMA_PRIORITY_EN
//     undefined (default): ties are resolved round-robin against last_owner.
//     defined            : ties go to DMA until MAX_DMA_BURST consecutive DMA
//                          grants have been made while the CPU waited. The next
//                          tie then goes to the CPU.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_STATES   = 1,  // 0..15
  parameter int unsigned MAX_DMA_BURST = 4   // 1..7, priority build only
) (
  input  logic clk,
  input  logic n_rst,
  input  logic cpu_req,
  output logic cpu_n_rdy,
  input  logic dma_req,
  output logic dma_ack,
  output logic bus_sel,
  output logic n_bus_en
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_t;

  localparam logic [3:0] CNT_LOAD  = 4'(WAIT_STATES);
  localparam logic [2:0] BURST_MAX = 3'(MAX_DMA_BURST);

  state_t     state;
  owner_t     last_owner;
  logic [3:0] cnt;
  logic [2:0] burst;

  logic arb_point;
  logic grant_cpu;
  logic grant_dma;
  logic burst_full;

  // Arbitration happens while idle, or on the final cycle of an access.
  assign arb_point  = (state == IDLE) || (cnt == 4'd0);
  assign burst_full = (burst == BURST_MAX);

  // Pick the next owner from the current requests.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else tree can leave it unassigned and infer a latch.
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (arb_point) begin
      if (cpu_req && dma_req) begin
`ifdef ARB_DMA_PRIORITY_EN
        // DMA wins ties until it has taken its burst allowance.
        if (burst_full) grant_cpu = 1'b1;
        else            grant_dma = 1'b1;
`else
        // Round-robin: whoever did not own the bus last goes next.
        if (last_owner == OWNER_DMA) grant_cpu = 1'b1;
        else                         grant_dma = 1'b1;
`endif
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end else if (dma_req) begin
        grant_dma = 1'b1;
      end
    end
  end

  // Access sequencer: grants, wait-state countdown and mux select.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      bus_sel    <= 1'b0;
      last_owner <= OWNER_DMA;  // CPU wins the first tie after reset
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples values from before the edge, independent of statement order.
      if (grant_cpu) begin
        state      <= CPU_ACC;
        cnt        <= CNT_LOAD;
        bus_sel    <= 1'b0;
        last_owner <= OWNER_CPU;
      end else if (grant_dma) begin
        state      <= DMA_ACC;
        cnt        <= CNT_LOAD;
        bus_sel    <= 1'b1;
        last_owner <= OWNER_DMA;
      end else if (arb_point) begin
        // Nobody asked: park in IDLE, bus_sel keeps its last value.
        state <= IDLE;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Consecutive DMA grants taken while the CPU was kept waiting.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      burst <= 3'd0;
    end else if (!cpu_req || grant_cpu) begin
      burst <= 3'd0;
    end else if (grant_dma && (burst < BURST_MAX)) begin
      burst <= burst + 3'd1;
    end
  end

  // Moore output decode.
  assign n_bus_en  = (state == IDLE);
  assign cpu_n_rdy = !((state == CPU_ACC) && (cnt == 4'd0));
  assign dma_ack   = (state == DMA_ACC) && (cnt == 4'd0);

endmodule
